// File: rtl/knn_topk_vote.sv
// knn_topk_vote
//   Keeps the K smallest (distance, label) pairs of one test image in a sorted
//   register file. After the last pair it runs a majority vote over the kept
//   labels and reports the predicted digit. Block-level ap_start/ap_done/ap_idle
//   handshake.
//
// Ports
//   ap_clk, ap_rst      clock, synchronous active-high reset
//   ap_start            start one classification (sampled only in IDLE)
//   ap_idle             high while idle
//   ap_done             one-cycle pulse when predicted_label/min_dist are valid
//   in_valid/in_ready   pair handshake, transfer = in_valid & in_ready
//   in_dist, in_label   distance to one training image and its label
//   in_last             marks the final pair of the test image
//   predicted_label     voted label, held until the next result
//   min_dist            nearest distance, held with predicted_label
//
// state   | meaning
// IDLE    | waiting for ap_start, result outputs held
// COLLECT | accepting pairs, one sorted insert per transfer
// VOTE    | one class index per cycle, NUM_CLASSES cycles
// DONE    | ap_done pulse, result registered on entry
module knn_topk_vote #(
   parameter int K           = 3,
   parameter int DIST_W      = 32,
   parameter int LABEL_W     = 4,
   parameter int NUM_CLASSES = 10
) (
   input  logic               ap_clk,
   input  logic               ap_rst,
   input  logic               ap_start,
   output logic               ap_idle,
   output logic               ap_done,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DIST_W-1:0]  in_dist,
   input  logic [LABEL_W-1:0] in_label,
   input  logic               in_last,
   output logic [LABEL_W-1:0] predicted_label,
   output logic [DIST_W-1:0]  min_dist
);

   localparam int CNT_W  = $clog2(K + 1);
   localparam int RANK_W = $clog2(K + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VOTE    = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t state;

   logic [DIST_W-1:0]  dist_q  [K];
   logic [LABEL_W-1:0] label_q [K];
   logic [K-1:0]       valid_q;

   logic [LABEL_W-1:0] vote_c;
   logic [CNT_W-1:0]   best_count;
   logic [RANK_W-1:0]  best_rank;
   logic [LABEL_W-1:0] best_class;

   // Insert position: first slot that is empty or holds a strictly larger
   // distance. Slots after it shift down; equal distances keep arrival order.
   logic [K-1:0] take;
   logic [K-1:0] shift;
   logic         hit_seen;
   logic         hit;

   always_comb begin
      take     = '0;
      shift    = '0;
      hit_seen = 1'b0;
      hit      = 1'b0;
      for (int i = 0; i < K; i++) begin
         hit      = !valid_q[i] || (in_dist < dist_q[i]);
         take[i]  = hit && !hit_seen;
         shift[i] = hit_seen;
         hit_seen = hit_seen || hit;
      end
   end

   // Vote for the current class: occurrence count and nearest slot holding it.
   logic [CNT_W-1:0]  cur_count;
   logic [RANK_W-1:0] cur_rank;
   logic              cur_better;

   always_comb begin
      cur_count = '0;
      cur_rank  = RANK_W'(K);
      for (int i = K - 1; i >= 0; i--) begin
         if (valid_q[i] && (label_q[i] == vote_c)) begin
            cur_count = cur_count + CNT_W'(1);
            cur_rank  = RANK_W'(i);
         end
      end
      cur_better = (cur_count > best_count) ||
                   ((cur_count == best_count) && (cur_count != '0) &&
                    (cur_rank < best_rank));
   end

   wire xfer = in_valid && in_ready;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state           <= IDLE;
         ap_idle         <= 1'b1;
         ap_done         <= 1'b0;
         in_ready        <= 1'b0;
         predicted_label <= '0;
         min_dist        <= '1;
         valid_q         <= '0;
         for (int i = 0; i < K; i++) begin
            dist_q[i]  <= '1;
            label_q[i] <= '0;
         end
         vote_c     <= '0;
         best_count <= '0;
         best_rank  <= RANK_W'(K);
         best_class <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ap_start) begin
                  valid_q  <= '0;
                  state    <= COLLECT;
                  ap_idle  <= 1'b0;
                  in_ready <= 1'b1;
               end
            end

            COLLECT: begin
               if (xfer) begin
                  for (int i = 1; i < K; i++) begin
                     if (shift[i]) begin
                        dist_q[i]  <= dist_q[i-1];
                        label_q[i] <= label_q[i-1];
                        valid_q[i] <= valid_q[i-1];
                     end
                  end
                  for (int i = 0; i < K; i++) begin
                     if (take[i]) begin
                        dist_q[i]  <= in_dist;
                        label_q[i] <= in_label;
                        valid_q[i] <= 1'b1;
                     end
                  end
                  if (in_last) begin
                     state      <= VOTE;
                     in_ready   <= 1'b0;
                     vote_c     <= '0;
                     best_count <= '0;
                     best_rank  <= RANK_W'(K);
                     best_class <= '0;
                  end
               end
            end

            VOTE: begin
               if (cur_better) begin
                  best_count <= cur_count;
                  best_rank  <= cur_rank;
                  best_class <= vote_c;
               end
               if (vote_c == LABEL_W'(NUM_CLASSES - 1)) begin
                  // Last class: fold its vote straight into the result.
                  predicted_label <= cur_better ? vote_c : best_class;
                  min_dist        <= dist_q[0];
                  ap_done         <= 1'b1;
                  state           <= DONE;
               end else begin
                  vote_c <= vote_c + LABEL_W'(1);
               end
            end

            DONE: begin
               ap_done <= 1'b0;
               ap_idle <= 1'b1;
               state   <= IDLE;
            end

            default: begin
               state    <= IDLE;
               ap_idle  <= 1'b1;
               ap_done  <= 1'b0;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
